// File: rtl/comp_mult_pkg.sv
// comp_mult_pkg: shared encodings for the complex-multiplier memory engine.
// Holds read/write FSM state codes and per-operation byte counts.
// No logic; imported by the engine top.
package comp_mult_pkg;

  // Read FSM: fetch operand bytes, present them, wait for results to drain
  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_FETCH   = 2'd1;
  localparam logic [1:0] R_PRESENT = 2'd2;
  localparam logic [1:0] R_DONE    = 2'd3;

  // Write FSM: wait for a result, then store it byte by byte
  localparam logic W_IDLE  = 1'b0;
  localparam logic W_STORE = 1'b1;

  // Bytes per operand set {x1,x2,y1,y2} and per result {xr,yr}
  localparam int OP_BYTES  = 4;
  localparam int RES_BYTES = 6;

endpackage

// File: rtl/comp_mult_mem_ctrl_if.sv
// comp_mult_mem_ctrl_if: memory port plus operand/result streams of the engine.
// master = engine side (drives memory, op stream, res_rdy); slave = memory/multiplier side.
// Both streams are valid/ready; mem_rd_data returns one cycle after a read access.
interface comp_mult_mem_ctrl_if #(
  parameter int SYS_AW = 16,
  parameter int DWIDTH = 8,
  parameter int RWIDTH = 24
);
  logic                mem_ce;
  logic                mem_we;
  logic [SYS_AW-1:0]   mem_addr;
  logic [7:0]          mem_wr_data;
  logic [7:0]          mem_rd_data;
  logic                op_val;
  logic                op_rdy;
  logic [4*DWIDTH-1:0] op_data;
  logic                res_val;
  logic                res_rdy;
  logic [2*RWIDTH-1:0] res_data;

  modport master (
    output mem_ce, mem_we, mem_addr, mem_wr_data, op_val, op_data, res_rdy,
    input  mem_rd_data, op_rdy, res_val, res_data
  );

  modport slave (
    input  mem_ce, mem_we, mem_addr, mem_wr_data, op_val, op_data, res_rdy,
    output mem_rd_data, op_rdy, res_val, res_data
  );
endinterface

// File: rtl/comp_mult_mem_arb.sv
// comp_mult_mem_arb: fixed-priority arbiter for the single-port memory (write wins over read).
// Ports: rd/wr request+address, grants, rd_cap_o (read data valid this cycle), memory port.
// Grants are combinational; a stalled read simply keeps requesting; sw_rst_i blocks all access.
module comp_mult_mem_arb #(
  parameter int SYS_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_i,
  input  logic              rd_req_i,
  input  logic [SYS_AW-1:0] rd_addr_i,
  input  logic              wr_req_i,
  input  logic [SYS_AW-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  output logic              rd_gnt_o,
  output logic              wr_gnt_o,
  output logic              rd_cap_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [SYS_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_wr_data_o
);
  logic rd_issued_q;

  assign wr_gnt_o      = wr_req_i & ~sw_rst_i;
  assign rd_gnt_o      = rd_req_i & ~wr_req_i & ~sw_rst_i;
  assign mem_ce_o      = wr_gnt_o | rd_gnt_o;
  assign mem_we_o      = wr_gnt_o;
  assign mem_addr_o    = wr_gnt_o ? wr_addr_i : (rd_gnt_o ? rd_addr_i : '0);
  assign mem_wr_data_o = wr_gnt_o ? wr_data_i : 8'h00;

  // Read data is valid exactly one cycle after the granted read, not after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_issued_q <= 1'b0;
    else        rd_issued_q <= rd_gnt_o & ~sw_rst_i;
  end

  assign rd_cap_o = rd_issued_q;
endmodule

// File: rtl/comp_mult_mem_ctrl.sv
// comp_mult_mem_ctrl: DMA engine fetching {x1,x2,y1,y2} operand sets and storing {xr,yr} results.
// Ports: clk/rst_n, sw_rst_i, start_i, base addresses + op count, busy_o/stop_o, bus (memory + streams).
// Min 10 port cycles/op (4 reads + 6 writes); op_val held until op_rdy; res_rdy only while result buffer empty.
module comp_mult_mem_ctrl
  import comp_mult_pkg::*;
#(
  parameter int SYS_AW = 16,
  parameter int REG_DW = 16,
  parameter int DWIDTH = 8,
  parameter int RWIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw_rst_i,
  input  logic                 start_i,
  input  logic [REG_DW-1:0]    op1_ba_i,
  input  logic [REG_DW-1:0]    op2_ba_i,
  input  logic [REG_DW-1:0]    res_ba_i,
  input  logic [REG_DW-1:0]    nr_op_i,
  output logic                 busy_o,
  output logic                 stop_o,
  comp_mult_mem_ctrl_if.master bus
);
  logic                busy_q, busy_d, stop_q, stop_d;
  logic [REG_DW-1:0]   op1_q, op1_d, op2_q, op2_d, res_q, res_d, nr_q, nr_d;
  logic [REG_DW-1:0]   op_cnt_q, op_cnt_d, res_cnt_q, res_cnt_d;
  logic [1:0]          r_state_q, r_state_d;
  logic                w_state_q, w_state_d;
  logic [2:0]          iss_q, iss_d;
  logic [1:0]          cap_q, cap_d;
  logic [4*DWIDTH-1:0] opbuf_q, opbuf_d;
  logic [SYS_AW-1:0]   rd_off_q, rd_off_d, wr_off_q, wr_off_d;
  logic [2*RWIDTH-1:0] resbuf_q, resbuf_d;
  logic [2:0]          wk_q, wk_d;
  logic                start_acc, done, op_hs, res_hs;
  logic                rd_req, wr_req, rd_gnt, wr_gnt, rd_cap;
  logic [SYS_AW-1:0]   rd_base, rd_addr, wr_addr;

  assign start_acc = start_i & ~busy_q;
  assign done      = busy_q & (r_state_q == R_DONE) & (res_cnt_q == nr_q) & (w_state_q == W_IDLE);
  assign op_hs     = bus.op_val & bus.op_rdy;
  assign res_hs    = bus.res_val & bus.res_rdy;

  // Issue order x1, x2, y1, y2: bit 0 picks the operand array, bit 1 the +1 (imaginary) byte
  assign rd_req  = (r_state_q == R_FETCH) && (iss_q < 3'(OP_BYTES));
  assign rd_base = iss_q[0] ? SYS_AW'(op2_q) : SYS_AW'(op1_q);
  assign rd_addr = rd_base + rd_off_q + SYS_AW'(iss_q[1]);
  assign wr_req  = (w_state_q == W_STORE);
  assign wr_addr = SYS_AW'(res_q) + wr_off_q;

  comp_mult_mem_arb #(.SYS_AW(SYS_AW)) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_rst_i      (sw_rst_i),
    .rd_req_i      (rd_req),
    .rd_addr_i     (rd_addr),
    .wr_req_i      (wr_req),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (resbuf_q[2*RWIDTH-1 -: 8]),
    .rd_gnt_o      (rd_gnt),
    .wr_gnt_o      (wr_gnt),
    .rd_cap_o      (rd_cap),
    .mem_ce_o      (bus.mem_ce),
    .mem_we_o      (bus.mem_we),
    .mem_addr_o    (bus.mem_addr),
    .mem_wr_data_o (bus.mem_wr_data)
  );

  assign bus.op_val  = (r_state_q == R_PRESENT);
  assign bus.op_data = opbuf_q;
  // Empty buffer == write FSM idle; refuse results when not running or in the completion cycle
  assign bus.res_rdy = busy_q & (w_state_q == W_IDLE) & ~done & ~sw_rst_i;
  assign busy_o      = busy_q;
  assign stop_o      = stop_q;

  // Control, config latch and status
  always_comb begin
    busy_d = busy_q;
    stop_d = stop_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    res_d  = res_q;
    nr_d   = nr_q;
    if (start_acc) begin
      busy_d = 1'b1;
      stop_d = 1'b0;
      op1_d  = op1_ba_i;
      op2_d  = op2_ba_i;
      res_d  = res_ba_i;
      nr_d   = nr_op_i;
    end else if (done) begin
      busy_d = 1'b0;
      stop_d = 1'b1;
    end
    if (sw_rst_i) begin
      {busy_d, stop_d, op1_d, op2_d, res_d, nr_d} = '0;
    end
  end

  // Read FSM
  always_comb begin
    r_state_d = r_state_q;
    op_cnt_d  = op_cnt_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    opbuf_d   = opbuf_q;
    rd_off_d  = rd_off_q;
    if (rd_gnt) iss_d = iss_q + 3'd1;
    // Shift captured bytes in so the first issued (x1) ends up in the top byte
    if (rd_cap) begin
      opbuf_d = {opbuf_q[3*DWIDTH-1:0], bus.mem_rd_data};
      cap_d   = cap_q + 2'd1;
    end
    case (r_state_q)
      R_IDLE: begin
        if (start_acc) begin
          op_cnt_d  = '0;
          rd_off_d  = '0;
          iss_d     = '0;
          cap_d     = '0;
          r_state_d = (nr_op_i != '0) ? R_FETCH : R_DONE;
        end
      end
      R_FETCH: begin
        if (rd_cap && (cap_q == 2'(OP_BYTES - 1))) r_state_d = R_PRESENT;
      end
      R_PRESENT: begin
        if (op_hs) begin
          op_cnt_d  = op_cnt_q + REG_DW'(1);
          rd_off_d  = rd_off_q + SYS_AW'(2);
          iss_d     = '0;
          cap_d     = '0;
          r_state_d = ((op_cnt_q + REG_DW'(1)) < nr_q) ? R_FETCH : R_DONE;
        end
      end
      default: begin
        if (done) r_state_d = R_IDLE;
      end
    endcase
    if (sw_rst_i) begin
      {r_state_d, op_cnt_d, iss_d, cap_d, opbuf_d, rd_off_d} = '0;
    end
  end

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    res_cnt_d = res_cnt_q;
    resbuf_d  = resbuf_q;
    wk_d      = wk_q;
    wr_off_d  = wr_off_q;
    if (start_acc) begin
      res_cnt_d = '0;
      wr_off_d  = '0;
    end
    case (w_state_q)
      W_IDLE: begin
        if (res_hs) begin
          resbuf_d  = bus.res_data;
          wk_d      = '0;
          w_state_d = W_STORE;
        end
      end
      default: begin
        if (wr_gnt) begin
          resbuf_d = resbuf_q << 8;
          wk_d     = wk_q + 3'd1;
          wr_off_d = wr_off_q + SYS_AW'(1);
          if (wk_q == 3'(RES_BYTES - 1)) begin
            w_state_d = W_IDLE;
            res_cnt_d = res_cnt_q + REG_DW'(1);
          end
        end
      end
    endcase
    if (sw_rst_i) begin
      {w_state_d, res_cnt_d, resbuf_d, wk_d, wr_off_d} = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {busy_q, stop_q, op1_q, op2_q, res_q, nr_q} <= '0;
      {r_state_q, op_cnt_q, iss_q, cap_q, opbuf_q, rd_off_q} <= '0;
      {w_state_q, res_cnt_q, resbuf_q, wk_q, wr_off_q} <= '0;
    end else begin
      {busy_q, stop_q, op1_q, op2_q, res_q, nr_q} <= {busy_d, stop_d, op1_d, op2_d, res_d, nr_d};
      {r_state_q, op_cnt_q, iss_q, cap_q, opbuf_q, rd_off_q} <=
        {r_state_d, op_cnt_d, iss_d, cap_d, opbuf_d, rd_off_d};
      {w_state_q, res_cnt_q, resbuf_q, wk_q, wr_off_q} <=
        {w_state_d, res_cnt_d, resbuf_d, wk_d, wr_off_d};
    end
  end
endmodule

// File: tb/tb_comp_mult_mem_ctrl.sv
// tb_comp_mult_mem_ctrl: randomized bench for the complex-multiplier memory engine.
// Operand image and result memory are separate arrays; a queued multiplier answers with random latency.
// Expected operands/results come from the operand image and plain complex arithmetic.
module tb_comp_mult_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sw_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op1_ba = '0, op2_ba = '0, res_ba = '0, nr_op = '0;
  logic        busy, stop;

  comp_mult_mem_ctrl_if #(.SYS_AW(16), .DWIDTH(8), .RWIDTH(24)) bus ();

  comp_mult_mem_ctrl #(.SYS_AW(16), .REG_DW(16), .DWIDTH(8), .RWIDTH(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_rst_i (sw_rst),
    .start_i  (start),
    .op1_ba_i (op1_ba),
    .op2_ba_i (op2_ba),
    .res_ba_i (res_ba),
    .nr_op_i  (nr_op),
    .busy_o   (busy),
    .stop_o   (stop),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  img  [0:65535];
  logic [7:0]  wmem [0:65535];
  int          wr_cnt = 0, ce_cnt = 0, opv_cnt = 0, wd_bad = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_op = '0;

  // Single-port byte memory: reads return next cycle, writes land in wmem
  always @(posedge clk) begin
    if (bus.mem_ce) begin
      ce_cnt++;
      if (bus.mem_we) begin
        wmem[bus.mem_addr] = bus.mem_wr_data;
        wr_cnt++;
      end else begin
        bus.mem_rd_data <= img[bus.mem_addr];
      end
    end
    if (!bus.mem_we && bus.mem_wr_data != 8'h00) wd_bad++;
    if (bus.op_val) opv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_op(input logic [15:0] a1, input logic [15:0] a2, input int i);
    logic [15:0] p1, p2;
    p1 = a1 + 16'(2 * i);
    p2 = a2 + 16'(2 * i);
    return {img[p1], img[p2], img[p1 + 16'd1], img[p2 + 16'd1]};
  endfunction

  // (x1 + j*y1) * (x2 + j*y2) with signed byte components, 24-bit results
  function automatic logic [47:0] cmul(input logic [31:0] d);
    int x1, x2, y1, y2, xr, yr;
    x1 = $signed(d[31:24]);
    x2 = $signed(d[23:16]);
    y1 = $signed(d[15:8]);
    y2 = $signed(d[7:0]);
    xr = x1 * x2 - y1 * y2;
    yr = x1 * y2 + y1 * x2;
    return {xr[23:0], yr[23:0]};
  endfunction

  task automatic run_ops(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] ar,
                         input logic [15:0] n, input int junk_at, input int rst_at,
                         output bit done_ok, output bit hit);
    int          cyc, seen;
    int          pend_due[$];
    logic [47:0] pend_dat[$];
    bit          drop;
    cyc = 0; seen = 0; drop = 0; done_ok = 0; hit = 0;
    op2_ba = a2;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (drop) begin
        bus.res_val = 1'b0;
        drop = 0;
      end
      start = (cyc == 1) || (cyc == junk_at);
      if (cyc == junk_at) begin
        op1_ba = a1 ^ 16'h5555; res_ba = ar ^ 16'h0F0F; nr_op = n + 16'd7;
      end else begin
        op1_ba = a1; res_ba = ar; nr_op = n;
      end
      bus.op_rdy = ($urandom_range(0, 3) != 0);
      if (!bus.res_val && pend_due.size() > 0 && pend_due[0] <= cyc && $urandom_range(0, 2) != 0) begin
        bus.res_val  = 1'b1;
        bus.res_data = pend_dat.pop_front();
        void'(pend_due.pop_front());
      end
      if (rst_at >= 0 && wr_cnt == rst_at) begin
        sw_rst = 1'b1; bus.op_rdy = 1'b0; bus.res_val = 1'b0; hit = 1;
        break;
      end
      #1;
      if (bus.op_val && bus.op_rdy) begin
        chk("op_data", bus.op_data, exp_op(a1, a2, seen));
        last_op = bus.op_data;
        pend_dat.push_back(cmul(bus.op_data));
        pend_due.push_back(cyc + int'($urandom_range(1, 8)));
        seen++;
      end
      if (bus.res_val && bus.res_rdy) drop = 1;
      if (stop && cyc > 1) begin
        done_ok = 1;
        break;
      end
    end
    start = 1'b0; bus.op_rdy = 1'b0; bus.res_val = 1'b0;
    if (rst_at < 0) chk("op_count", seen, n);
  endtask

  task automatic check_results(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] ar,
                               input int n, input int w0, input int c0, input bit done_ok);
    logic [47:0] r;
    logic [7:0]  b;
    logic [15:0] ad;
    chk("done", done_ok, 1);
    chk("end_busy", busy, 0);
    chk("end_stop", stop, 1);
    chk("end_res_rdy", bus.res_rdy, 0);
    chk("write_count", wr_cnt - w0, 6 * n);
    chk("access_count", ce_cnt - c0, 10 * n);
    for (int i = 0; i < n; i++) begin
      r = cmul(exp_op(a1, a2, i));
      for (int k = 0; k < 6; k++) begin
        b  = r[47 - 8 * k -: 8];
        ad = ar + 16'(6 * i + k);
        chk("res_byte", wmem[ad], b);
      end
    end
  endtask

  initial begin
    bit          ok, hit;
    int          w0, c0, v0;
    logic [47:0] fixed;
    bus.op_rdy = 1'b0; bus.res_val = 1'b0; bus.res_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stop", stop, 0);
    chk("rst_mem_ce", bus.mem_ce, 0);
    chk("rst_op_val", bus.op_val, 0);
    chk("rst_res_rdy", bus.res_rdy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single op
    img[500] = 8'd3; img[501] = 8'd4; img[1500] = 8'd5; img[1501] = 8'd6;
    w0 = wr_cnt; c0 = ce_cnt;
    run_ops(16'd500, 16'd1500, 16'd4500, 16'd1, -1, -1, ok, hit);
    chk("t1_op_data", last_op, 32'h03050406);
    fixed = 48'hFFFFF7_000026;
    for (int k = 0; k < 6; k++) chk("t1_byte", wmem[4500 + k], fixed[47 - 8 * k -: 8]);
    check_results(16'd500, 16'd1500, 16'd4500, 1, w0, c0, ok);

    // 300 random ops, with an ignored start pulse mid-run
    for (int i = 0; i < 600; i++) begin
      img[16'h1000 + i] = 8'($urandom);
      img[16'h2000 + i] = 8'($urandom);
    end
    w0 = wr_cnt; c0 = ce_cnt;
    run_ops(16'h1000, 16'h2000, 16'h8000, 16'd300, 500, -1, ok, hit);
    check_results(16'h1000, 16'h2000, 16'h8000, 300, w0, c0, ok);
    chk("wr_data_idle_zero", wd_bad, 0);

    // nr_op == 0
    c0 = ce_cnt; v0 = opv_cnt;
    nr_op = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_busy_pulse", busy, 1);
    chk("zero_stop_clear", stop, 0);
    @(negedge clk);
    #1;
    chk("zero_busy_end", busy, 0);
    chk("zero_stop_set", stop, 1);
    repeat (3) @(negedge clk);
    chk("zero_no_access", ce_cnt - c0, 0);
    chk("zero_no_op_val", opv_cnt - v0, 0);

    // Address wrap for operands and results
    img[16'hFFFF] = 8'($urandom);
    for (int i = 0; i < 3; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) img[16'h0100 + i] = 8'($urandom);
    w0 = wr_cnt; c0 = ce_cnt;
    run_ops(16'hFFFF, 16'h0100, 16'hFFFA, 16'd2, -1, -1, ok, hit);
    check_results(16'hFFFF, 16'h0100, 16'hFFFA, 2, w0, c0, ok);

    // sw_rst while storing op 5, then a fresh run
    for (int i = 0; i < 40; i++) begin
      img[16'h3000 + i] = 8'($urandom);
      img[16'h3100 + i] = 8'($urandom);
    end
    w0 = wr_cnt;
    run_ops(16'h3000, 16'h3100, 16'h9000, 16'd20, -1, w0 + 32, ok, hit);
    chk("swrst_hit", hit, 1);
    @(negedge clk);
    sw_rst = 1'b0;
    #1;
    chk("swrst_no_write", wr_cnt, w0 + 32);
    chk("swrst_busy", busy, 0);
    chk("swrst_stop", stop, 0);
    chk("swrst_mem_ce", bus.mem_ce, 0);
    chk("swrst_mem_we", bus.mem_we, 0);
    chk("swrst_mem_addr", bus.mem_addr, 0);
    chk("swrst_op_val", bus.op_val, 0);
    chk("swrst_res_rdy", bus.res_rdy, 0);
    c0 = ce_cnt;
    repeat (20) @(negedge clk);
    chk("swrst_quiet", ce_cnt - c0, 0);
    w0 = wr_cnt; c0 = ce_cnt;
    run_ops(16'h3000, 16'h3100, 16'h9800, 16'd3, -1, -1, ok, hit);
    check_results(16'h3000, 16'h3100, 16'h9800, 3, w0, c0, ok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
